// File: rtl/jtag_tap_pkg.sv
// Shared types and constants for the oversampled JTAG TAP.
package jtag_tap_pkg;

    // IEEE 1149.1 TAP controller states, conventional 4-bit encoding.
    typedef enum logic [3:0] {
        TLR    = 4'hF,
        RTI    = 4'hC,
        SEL_DR = 4'h7,
        CAP_DR = 4'h6,
        SH_DR  = 4'h2,
        EX1_DR = 4'h1,
        PAU_DR = 4'h3,
        EX2_DR = 4'h0,
        UPD_DR = 4'h5,
        SEL_IR = 4'h4,
        CAP_IR = 4'hE,
        SH_IR  = 4'hA,
        EX1_IR = 4'h9,
        PAU_IR = 4'hB,
        EX2_IR = 4'h8,
        UPD_IR = 4'hD
    } tap_state_e;

    // Data register selected by the current instruction.
    typedef enum logic [1:0] {
        DR_BYPASS  = 2'd0,
        DR_IDCODE  = 2'd1,
        DR_CONFREG = 2'd2
    } dr_sel_e;

    localparam logic [4:0] IR_IDCODE  = 5'b00001;
    localparam logic [4:0] IR_CONFREG = 5'b00110;
    localparam logic [4:0] IR_BYPASS  = 5'b11111;
    localparam logic [4:0] IR_CAPTURE = 5'b00001;

endpackage

// File: rtl/jtag_edge_sync.sv
// Synchronises tck/tms/tdi into clk_i and derives single-cycle tck edge pulses.
module jtag_edge_sync (
    input  logic clk_i,
    input  logic rst_n,
    input  logic tck,
    input  logic tms,
    input  logic tdi,
    output logic tck_rise_c,
    output logic tck_fall_c,
    output logic tms_s,
    output logic tdi_s
);

    logic [2:0] tck_ff;
    logic       tms_ff;
    logic       tdi_ff;

    // Two-flop synchronisers plus a third tck flop for edge detection.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            tck_ff <= 3'b000;
            tms_ff <= 1'b0;
            tdi_ff <= 1'b0;
            tms_s  <= 1'b0;
            tdi_s  <= 1'b0;
        end else begin
            tck_ff <= {tck_ff[1:0], tck};
            tms_ff <= tms;
            tdi_ff <= tdi;
            tms_s  <= tms_ff;
            tdi_s  <= tdi_ff;
        end
    end

    // tck_ff[1] is s2, tck_ff[2] is s3; tms_s/tdi_s line up with s2.
    assign tck_rise_c = tck_ff[1] & ~tck_ff[2];
    assign tck_fall_c = ~tck_ff[1] & tck_ff[2];

endmodule

// File: rtl/jtag_tap_oversampled.sv
// JTAG TAP responder oversampled on clk_i: IDCODE, BYPASS and CONFREG.
// Optional feature macro JTAG_TRST_EN adds the jtag_trst_ni reset input.
module jtag_tap_oversampled
    import jtag_tap_pkg::*;
#(
    parameter logic [31:0]       IDCODE_VAL = 32'h1000_0DB3,
    parameter int unsigned       IR_W       = 5,
    parameter int unsigned       CONF_W     = 9,
    parameter logic [CONF_W-1:0] CONF_RST   = '0
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              jtag_tck_i,
    input  logic              jtag_tms_i,
    input  logic              jtag_tdi_i,
`ifdef JTAG_TRST_EN
    input  logic              jtag_trst_ni,
`endif
    output logic              jtag_tdo_o,
    output logic              jtag_tdo_en_o,
    output logic [CONF_W-1:0] conf_o,
    output logic              conf_upd_o,
    output logic [3:0]        tap_state_o
);

    logic tck_rise_c;
    logic tck_fall_c;
    logic tms_s;
    logic tdi_s;
    logic trst_n_s;

    tap_state_e        state_q;
    tap_state_e        state_d;
    dr_sel_e           dr_sel;
    logic [IR_W-1:0]   ir_q;
    logic [IR_W-1:0]   ir_sr;
    logic [31:0]       id_sr;
    logic              byp_sr;
    logic [CONF_W-1:0] conf_sr;
    logic              tdo_stage;

    jtag_edge_sync u_sync (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .tck        (jtag_tck_i),
        .tms        (jtag_tms_i),
        .tdi        (jtag_tdi_i),
        .tck_rise_c (tck_rise_c),
        .tck_fall_c (tck_fall_c),
        .tms_s      (tms_s),
        .tdi_s      (tdi_s)
    );

`ifdef JTAG_TRST_EN
    logic       trst_arst_n;
    logic [1:0] trst_ff;

    assign trst_arst_n = rst_n & jtag_trst_ni;

    // Async-assert, sync-release conditioning of the JTAG reset.
    always_ff @(posedge clk_i or negedge trst_arst_n) begin
        if (!trst_arst_n) begin
            trst_ff <= 2'b00;
        end else begin
            trst_ff <= {trst_ff[0], 1'b1};
        end
    end

    assign trst_n_s = trst_ff[1];
`else
    assign trst_n_s = 1'b1;
`endif

    // TAP state register.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    // IEEE 1149.1 next-state logic, advanced only on a synchronised tck rise.
    always_comb begin
        state_d = state_q;
        if (!trst_n_s) begin
            state_d = TLR;
        end else if (tck_rise_c) begin
            case (state_q)
                TLR:     state_d = tms_s ? TLR    : RTI;
                RTI:     state_d = tms_s ? SEL_DR : RTI;
                SEL_DR:  state_d = tms_s ? SEL_IR : CAP_DR;
                CAP_DR:  state_d = tms_s ? EX1_DR : SH_DR;
                SH_DR:   state_d = tms_s ? EX1_DR : SH_DR;
                EX1_DR:  state_d = tms_s ? UPD_DR : PAU_DR;
                PAU_DR:  state_d = tms_s ? EX2_DR : PAU_DR;
                EX2_DR:  state_d = tms_s ? UPD_DR : SH_DR;
                UPD_DR:  state_d = tms_s ? SEL_DR : RTI;
                SEL_IR:  state_d = tms_s ? TLR    : CAP_IR;
                CAP_IR:  state_d = tms_s ? EX1_IR : SH_IR;
                SH_IR:   state_d = tms_s ? EX1_IR : SH_IR;
                EX1_IR:  state_d = tms_s ? UPD_IR : PAU_IR;
                PAU_IR:  state_d = tms_s ? EX2_IR : PAU_IR;
                EX2_IR:  state_d = tms_s ? UPD_IR : SH_IR;
                UPD_IR:  state_d = tms_s ? SEL_DR : RTI;
                default: state_d = TLR;
            endcase
        end
    end

    // Instruction decode; unknown opcodes fall back to BYPASS.
    always_comb begin
        dr_sel = DR_BYPASS;
        if (ir_q == IR_W'(IR_IDCODE)) begin
            dr_sel = DR_IDCODE;
        end else if (ir_q == IR_W'(IR_CONFREG)) begin
            dr_sel = DR_CONFREG;
        end else if (ir_q == IR_W'(IR_BYPASS)) begin
            dr_sel = DR_BYPASS;
        end
    end

    // Capture/shift/update of IR and DR chains on rise; tdo launch on fall.
    // tdo_stage always holds the LSB of the active chain so the first bit
    // out after capture is the captured LSB.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            ir_q          <= IR_W'(IR_IDCODE);
            ir_sr         <= '0;
            id_sr         <= '0;
            byp_sr        <= 1'b0;
            conf_sr       <= '0;
            conf_o        <= CONF_RST;
            conf_upd_o    <= 1'b0;
            tdo_stage     <= 1'b0;
            jtag_tdo_o    <= 1'b0;
            jtag_tdo_en_o <= 1'b0;
        end else begin
            conf_upd_o <= 1'b0;
            if (!trst_n_s || state_q == TLR) begin
                ir_q   <= IR_W'(IR_IDCODE);
                conf_o <= CONF_RST;
            end else if (tck_rise_c) begin
                case (state_q)
                    CAP_DR: begin
                        case (dr_sel)
                            DR_IDCODE: begin
                                id_sr     <= IDCODE_VAL;
                                tdo_stage <= IDCODE_VAL[0];
                            end
                            DR_CONFREG: begin
                                conf_sr   <= conf_o;
                                tdo_stage <= conf_o[0];
                            end
                            default: begin
                                byp_sr    <= 1'b0;
                                tdo_stage <= 1'b0;
                            end
                        endcase
                    end
                    SH_DR: begin
                        case (dr_sel)
                            DR_IDCODE: begin
                                id_sr     <= {tdi_s, id_sr[31:1]};
                                tdo_stage <= id_sr[1];
                            end
                            DR_CONFREG: begin
                                conf_sr   <= {tdi_s, conf_sr[CONF_W-1:1]};
                                tdo_stage <= conf_sr[1];
                            end
                            default: begin
                                byp_sr    <= tdi_s;
                                tdo_stage <= tdi_s;
                            end
                        endcase
                    end
                    UPD_DR: begin
                        if (dr_sel == DR_CONFREG) begin
                            conf_o     <= conf_sr;
                            conf_upd_o <= 1'b1;
                        end
                    end
                    CAP_IR: begin
                        ir_sr     <= IR_W'(IR_CAPTURE);
                        tdo_stage <= IR_CAPTURE[0];
                    end
                    SH_IR: begin
                        ir_sr     <= {tdi_s, ir_sr[IR_W-1:1]};
                        tdo_stage <= ir_sr[1];
                    end
                    UPD_IR: begin
                        ir_q <= ir_sr;
                    end
                    default: begin
                    end
                endcase
            end
            if (tck_fall_c) begin
                jtag_tdo_o    <= tdo_stage;
                jtag_tdo_en_o <= (state_q == SH_DR) || (state_q == SH_IR);
            end
        end
    end

    assign tap_state_o = state_q;

endmodule
